// File: rtl/packet_sender.sv
// Packetizer: frames a send command plus payload words into header/body/tail flits.
// Define PACKET_SENDER_CHECKSUM_EN to carry the XOR of the body words in the tail.
module packet_sender #(
    parameter int FLIT_WIDTH     = 64,
    parameter int NODE_ID_WIDTH  = 8,
    parameter int SEQ_WIDTH      = 8,
    parameter int MAX_BODY_FLITS = 8,
    parameter int LEN_WIDTH      = $clog2(MAX_BODY_FLITS + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NODE_ID_WIDTH-1:0] my_id,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [NODE_ID_WIDTH-1:0] cmd_dst_id,
    input  logic [LEN_WIDTH-1:0]     cmd_len,
    input  logic                     body_valid,
    output logic                     body_ready,
    input  logic [FLIT_WIDTH-3:0]    body_data,
    output logic                     flit_valid,
    input  logic                     flit_ready,
    output logic [FLIT_WIDTH-1:0]    flit_data,
    output logic                     busy,
    output logic                     pkt_sent,
    output logic                     len_err,
    output logic [SEQ_WIDTH-1:0]     seq_num
);

    localparam int PAY_W = FLIT_WIDTH - 2;
    localparam int HDR_W = 2 * NODE_ID_WIDTH + SEQ_WIDTH + LEN_WIDTH;
    localparam int PAD_W = PAY_W - HDR_W;
    localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(MAX_BODY_FLITS);

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        BODY,
        TAIL
    } state_t;

    state_t state, state_nxt;

    logic [NODE_ID_WIDTH-1:0] src_q;
    logic [NODE_ID_WIDTH-1:0] dst_q;
    logic [LEN_WIDTH-1:0]     len_q;
    logic [LEN_WIDTH-1:0]     cnt_q;
    logic [LEN_WIDTH-1:0]     len_clamp;
    logic [PAY_W-1:0]         tail_pay;
    logic                     cmd_fire;
    logic                     body_fire;
    logic                     tail_fire;
    logic                     too_long;

    assign too_long  = cmd_len > MAX_LEN;
    assign len_clamp = too_long ? MAX_LEN : cmd_len;
    assign cmd_fire  = (state == IDLE) && cmd_valid;
    assign body_fire = (state == BODY) && body_valid && flit_ready;
    assign tail_fire = (state == TAIL) && flit_ready;
    assign busy      = (state != IDLE);

`ifdef PACKET_SENDER_CHECKSUM_EN
    logic [PAY_W-1:0] csum_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= '0;
        end else if (cmd_fire) begin
            csum_q <= '0;
        end else if (body_fire) begin
            csum_q <= csum_q ^ body_data;
        end
    end

    assign tail_pay = csum_q;
`else
    assign tail_pay = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q   <= '0;
            dst_q   <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            seq_num <= '0;
        end else begin
            if (cmd_fire) begin
                src_q <= my_id;
                dst_q <= cmd_dst_id;
                len_q <= len_clamp;
                cnt_q <= '0;
            end
            if (body_fire) begin
                cnt_q <= cnt_q + 1'b1;
            end
            // seq_num is frozen for the whole packet, so the header reads it live
            if (tail_fire) begin
                seq_num <= seq_num + 1'b1;
            end
        end
    end

    // pkt_sent is combinational: high in the same cycle as the tail handshake
    always_comb begin
        state_nxt  = state;
        cmd_ready  = 1'b0;
        flit_valid = 1'b0;
        body_ready = 1'b0;
        flit_data  = '0;
        pkt_sent   = 1'b0;
        len_err    = 1'b0;
        unique case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    len_err   = too_long;
                    state_nxt = HEADER;
                end
            end
            HEADER: begin
                flit_valid = 1'b1;
                flit_data  = {2'b00, src_q, dst_q, seq_num, len_q,
                              {PAD_W{1'b0}}};
                if (flit_ready) begin
                    state_nxt = (len_q != '0) ? BODY : TAIL;
                end
            end
            BODY: begin
                flit_valid = body_valid;
                body_ready = flit_ready;
                flit_data  = {2'b01, body_data};
                if (body_fire && (cnt_q == len_q - 1'b1)) begin
                    state_nxt = TAIL;
                end
            end
            TAIL: begin
                flit_valid = 1'b1;
                flit_data  = {2'b10, tail_pay};
                if (flit_ready) begin
                    pkt_sent  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
